// File: rtl/fdsp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fdsp_arbiter
// Purpose  : Round-robin arbiter that shares one floating-point DSP unit
//            among four requesters. It grants one requester, latches that
//            requester's opcode and operands, pulses dsp_start, waits for
//            dsp_done and then returns the result with a one-hot ack pulse.
// Revision : 1.0 - initial release
//
// Ports    : clk           - clock, all logic on the rising edge
//            resetn        - synchronous active-low reset
//            req[3:0]      - per-requester level request, held until ack
//            req_n[11:0]   - packed 3-bit opcodes, requester i at [3i+2:3i]
//            req_a[127:0]  - packed operand A, requester i at [32i+31:32i]
//            req_b[127:0]  - packed operand B, same packing as req_a
//            ack[3:0]      - one-hot completion pulse (RESP state only)
//            result[31:0]  - shared result, valid in the ack cycle
//            err           - watchdog timeout flag, valid in the ack cycle
//            busy          - high whenever the FSM is not idle
//            dsp_start     - one-cycle start pulse to the DSP
//            dsp_n         - latched opcode
//            dsp_dataa     - latched operand A
//            dsp_datab     - latched operand B
//            dsp_reset_req - one-cycle DSP abort request (watchdog)
//            dsp_done      - DSP completion strobe
//            dsp_result    - DSP result, sampled when dsp_done is high
//
// Config   : FDSP_ARB_TIMEOUT_EN - when defined, a watchdog aborts a DSP
//            operation after TIMEOUT cycles in WAIT, returning a quiet NaN
//            with err set. When undefined, err and dsp_reset_req are tied 0.
// ============================================================================
module fdsp_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [3:0]   req,
   input  logic [11:0]  req_n,
   input  logic [127:0] req_a,
   input  logic [127:0] req_b,
   output logic [3:0]   ack,
   output logic [31:0]  result,
   output logic         err,
   output logic         busy,
   output logic         dsp_start,
   output logic [2:0]   dsp_n,
   output logic [31:0]  dsp_dataa,
   output logic [31:0]  dsp_datab,
   output logic         dsp_reset_req,
   input  logic         dsp_done,
   input  logic [31:0]  dsp_result
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   // Unpacked views of the packed requester buses.
   logic [2:0]  n_arr [4];
   logic [31:0] a_arr [4];
   logic [31:0] b_arr [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      assign n_arr[gi] = req_n[3*gi +: 3];
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
   end

   logic [1:0]  state_q,     state_d;
   logic [1:0]  ptr_q,       ptr_d;
   logic [1:0]  gidx_q,      gidx_d;
   logic [31:0] result_q,    result_d;
   logic [2:0]  dsp_n_q,     dsp_n_d;
   logic [31:0] dsp_dataa_q, dsp_dataa_d;
   logic [31:0] dsp_datab_q, dsp_datab_d;

   // Round-robin search: start at ptr, wrap 3->0, first set bit wins.
   logic       grant_found;
   logic [1:0] grant_idx;
   logic [1:0] cand;

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr_q;
      cand        = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!grant_found && req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

`ifdef FDSP_ARB_TIMEOUT_EN
   localparam int WD_W = 16;

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            err_q, err_d;
   logic            dsp_reset_req_q, dsp_reset_req_d;
   logic            wd_fire;

   // Fires on the WAIT cycle in which the counter would reach TIMEOUT.
   assign wd_fire = (state_q == S_WAIT) && !dsp_done &&
                    ((wd_cnt_q + 1'b1) == WD_W'(TIMEOUT));
`else
   // Watchdog not built: TIMEOUT has no effect in this configuration.
   if (TIMEOUT < 1) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gidx_d      = gidx_q;
      result_d    = result_q;
      dsp_n_d     = dsp_n_q;
      dsp_dataa_d = dsp_dataa_q;
      dsp_datab_d = dsp_datab_q;
`ifdef FDSP_ARB_TIMEOUT_EN
      err_d           = err_q;
      dsp_reset_req_d = 1'b0;
      wd_cnt_d        = wd_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               gidx_d      = grant_idx;
               dsp_n_d     = n_arr[grant_idx];
               dsp_dataa_d = a_arr[grant_idx];
               dsp_datab_d = b_arr[grant_idx];
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
`ifdef FDSP_ARB_TIMEOUT_EN
            wd_cnt_d = '0;
`endif
            // A zero-latency DSP may complete in the start cycle itself.
            if (dsp_done) begin
               result_d = dsp_result;
`ifdef FDSP_ARB_TIMEOUT_EN
               err_d    = 1'b0;
`endif
               state_d  = S_RESP;
            end else begin
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
`ifdef FDSP_ARB_TIMEOUT_EN
            wd_cnt_d = wd_cnt_q + 1'b1;
`endif
            if (dsp_done) begin
               result_d = dsp_result;
`ifdef FDSP_ARB_TIMEOUT_EN
               err_d    = 1'b0;
`endif
               state_d  = S_RESP;
            end
`ifdef FDSP_ARB_TIMEOUT_EN
            else if (wd_fire) begin
               result_d        = 32'h7FC0_0000;
               err_d           = 1'b1;
               dsp_reset_req_d = 1'b1;
               state_d         = S_RESP;
            end
`endif
         end
         S_RESP: begin
            ptr_d   = gidx_q + 2'd1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         ptr_q       <= 2'd0;
         gidx_q      <= 2'd0;
         result_q    <= 32'd0;
         dsp_n_q     <= 3'd0;
         dsp_dataa_q <= 32'd0;
         dsp_datab_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gidx_q      <= gidx_d;
         result_q    <= result_d;
         dsp_n_q     <= dsp_n_d;
         dsp_dataa_q <= dsp_dataa_d;
         dsp_datab_q <= dsp_datab_d;
      end
   end

`ifdef FDSP_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wd_cnt_q        <= '0;
         err_q           <= 1'b0;
         dsp_reset_req_q <= 1'b0;
      end else begin
         wd_cnt_q        <= wd_cnt_d;
         err_q           <= err_d;
         dsp_reset_req_q <= dsp_reset_req_d;
      end
   end

   assign err           = err_q;
   assign dsp_reset_req = dsp_reset_req_q;
`else
   assign err           = 1'b0;
   assign dsp_reset_req = 1'b0;
`endif

   assign ack       = (state_q == S_RESP) ? (4'b0001 << gidx_q) : 4'b0000;
   assign result    = result_q;
   assign busy      = (state_q != S_IDLE);
   assign dsp_start = (state_q == S_ISSUE);
   assign dsp_n     = dsp_n_q;
   assign dsp_dataa = dsp_dataa_q;
   assign dsp_datab = dsp_datab_q;

endmodule
`default_nettype wire

// File: tb/tb_fdsp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdsp_arbiter
// Purpose  : Directed self-checking bench for fdsp_arbiter with a behavioural
//            DSP model of programmable latency and a queue of expected acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdsp_arbiter;

   logic         clk = 1'b0;
   logic         resetn;
   logic [3:0]   req;
   logic [11:0]  req_n;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [3:0]   ack;
   logic [31:0]  result;
   logic         err;
   logic         busy;
   logic         dsp_start;
   logic [2:0]   dsp_n;
   logic [31:0]  dsp_dataa;
   logic [31:0]  dsp_datab;
   logic         dsp_reset_req;
   logic         dsp_done = 1'b0;
   logic [31:0]  dsp_result = 32'd0;

   fdsp_arbiter #(.TIMEOUT(16)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .req           (req),
      .req_n         (req_n),
      .req_a         (req_a),
      .req_b         (req_b),
      .ack           (ack),
      .result        (result),
      .err           (err),
      .busy          (busy),
      .dsp_start     (dsp_start),
      .dsp_n         (dsp_n),
      .dsp_dataa     (dsp_dataa),
      .dsp_datab     (dsp_datab),
      .dsp_reset_req (dsp_reset_req),
      .dsp_done      (dsp_done),
      .dsp_result    (dsp_result)
   );

   always #5 clk = ~clk;

   // ---------------- DSP model: lat<0 never completes ----------------
   int          lat       = 3;
   logic        use_fixed = 1'b0;
   logic [31:0] fixed_val = 32'd0;
   int          m_cnt     = 0;
   logic [31:0] m_val     = 32'd0;

   always @(negedge clk) begin
      dsp_done = 1'b0;
      if (!resetn || dsp_reset_req) begin
         m_cnt = 0;
      end else if (dsp_start) begin
         m_val = use_fixed ? fixed_val : (dsp_dataa ^ dsp_datab ^ {29'd0, dsp_n});
         if (lat == 0) begin
            dsp_done   = 1'b1;
            dsp_result = m_val;
         end else if (lat > 0) begin
            m_cnt = lat;
         end
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            dsp_done   = 1'b1;
            dsp_result = m_val;
         end
      end
   end

   // ---------------- Output monitor ----------------
   int          cyc       = 0;
   int          ack_cnt   = 0;
   int          start_cnt = 0;
   int          rr_cnt    = 0;
   int          ack_cyc   = 0;
   int          start_cyc = 0;
   logic [3:0]  last_ack  = 4'd0;
   logic [31:0] last_res  = 32'd0;
   logic        last_err  = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (ack != 4'd0) begin
         ack_cnt  = ack_cnt + 1;
         ack_cyc  = cyc;
         last_ack = ack;
         last_res = result;
         last_err = err;
      end
      if (dsp_start) begin
         start_cnt = start_cnt + 1;
         start_cyc = cyc;
      end
      if (dsp_reset_req) rr_cnt = rr_cnt + 1;
   end

   // ---------------- Scoreboard and checks ----------------
   typedef struct {
      logic [3:0]  ack;
      logic [31:0] res;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   n_push  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_bad = n_bad + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_res(input int i);
      return req_a[32*i +: 32] ^ req_b[32*i +: 32] ^ {29'd0, req_n[3*i +: 3]};
   endfunction

   task automatic set_op(input int i, input logic [2:0] n, input logic [31:0] a,
                         input logic [31:0] b);
      req_n[3*i +: 3]  = n;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic push(input logic [3:0] a, input logic [31:0] r, input logic e);
      exp_t x;
      x.ack = a;
      x.res = r;
      x.err = e;
      sb.push_back(x);
      n_push = n_push + 1;
   endtask

   // Returns n = negedges counted from the call until ack is seen.
   task automatic wait_ack(input int budget, output int n);
      logic found;
      found = 1'b0;
      n     = 0;
      while (!found && n < budget) begin
         @(negedge clk);
         n = n + 1;
         if (ack != 4'd0) found = 1'b1;
      end
      #1;
      check("ack_wait", {31'd0, found}, 32'd1);
   endtask

   task automatic pop_check(input string tag);
      exp_t x;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         check({tag, "_ack"},    {28'd0, last_ack}, {28'd0, x.ack});
         check({tag, "_result"}, last_res,          x.res);
         check({tag, "_err"},    {31'd0, last_err}, {31'd0, x.err});
      end
   endtask

   task automatic gap();
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int n;
      int s0;
      int a0;
      logic [31:0] held_a;

      resetn = 1'b0;
      req    = 4'd0;
      req_n  = '0;
      req_a  = '0;
      req_b  = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ack",       {28'd0, ack},           32'd0);
      check("rst_result",    result,                 32'd0);
      check("rst_err",       {31'd0, err},           32'd0);
      check("rst_busy",      {31'd0, busy},          32'd0);
      check("rst_start",     {31'd0, dsp_start},     32'd0);
      check("rst_reset_req", {31'd0, dsp_reset_req}, 32'd0);
      check("rst_dsp_n",     {29'd0, dsp_n},         32'd0);
      check("rst_dataa",     dsp_dataa,              32'd0);
      check("rst_datab",     dsp_datab,              32'd0);
      resetn = 1'b1;
      gap();

      // Contention: all four held high, ptr starts at 0.
      for (int i = 0; i < 4; i++)
         set_op(i, 3'(i + 1), 32'hA000_0000 | 32'(i), 32'h0B00_0000 + 32'(i) * 32'h100);
      lat = 2;
      push(4'b0001, model_res(0), 1'b0);
      push(4'b0010, model_res(1), 1'b0);
      push(4'b0100, model_res(2), 1'b0);
      push(4'b1000, model_res(3), 1'b0);
      push(4'b0001, model_res(0), 1'b0);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(40, n);
         if (k == 4) req = 4'b0000;
         pop_check("contend");
      end
      gap();

      // Single request with fixed DSP answer, L=5: ack in the 8th cycle.
      set_op(0, 3'd0, 32'h3F80_0000, 32'h4000_0000);
      use_fixed = 1'b1;
      fixed_val = 32'h4040_0000;
      lat       = 5;
      s0        = start_cnt;
      push(4'b0001, 32'h4040_0000, 1'b0);
      req = 4'b0001;
      wait_ack(40, n);
      req = 4'b0000;
      pop_check("single");
      check("single_latency", 32'(n + 1), 32'd8);
      check("single_starts",  32'(start_cnt - s0), 32'd1);
      use_fixed = 1'b0;
      gap();

      // Done in the ISSUE cycle (L=0): ack 2 cycles inclusive of start.
      lat = 0;
      set_op(1, 3'd5, 32'h1234_5678, 32'h0F0F_0F0F);
      push(4'b0010, model_res(1), 1'b0);
      req = 4'b0010;
      wait_ack(40, n);
      req = 4'b0000;
      pop_check("issue_done");
      check("issue_done_cycles", 32'(ack_cyc - start_cyc + 1), 32'd2);
      gap();

      // Reset in WAIT: no ack, idle, ptr back to 0.
      lat = -1;
      a0  = ack_cnt;
      req = 4'b0010;
      repeat (4) @(negedge clk);
      #1;
      check("busy_in_wait", {31'd0, busy}, 32'd1);
      resetn = 1'b0;
      req    = 4'b0000;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_ack",  {28'd0, ack},  32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("rst_mid_no_ack", 32'(ack_cnt - a0), 32'd0);
      lat = 3;
      set_op(0, 3'd2, 32'h0000_1111, 32'h2222_0000);
      set_op(2, 3'd3, 32'h0000_3333, 32'h4444_0000);
      push(4'b0001, model_res(0), 1'b0);
      req = 4'b0101;
      wait_ack(40, n);
      req = 4'b0000;
      pop_check("post_rst_ptr");
      gap();
      push(4'b0100, model_res(2), 1'b0);
      req = 4'b0100;
      wait_ack(40, n);
      req = 4'b0000;
      pop_check("post_rst_req2");
      gap();

      // Drop mid-operation; latched operands must not follow the inputs.
      lat = 6;
      set_op(2, 3'd6, 32'hCAFE_0000, 32'h0000_BEEF);
      held_a = 32'hCAFE_0000;
      push(4'b0100, model_res(2), 1'b0);
      req = 4'b0100;
      repeat (3) @(negedge clk);
      #1;
      check("drop_busy", {31'd0, busy}, 32'd1);
      req = 4'b0000;
      set_op(2, 3'd1, 32'h5555_5555, 32'h6666_6666);
      @(negedge clk);
      #1;
      check("drop_dataa_stable", dsp_dataa, held_a);
      wait_ack(40, n);
      pop_check("drop");
      a0 = ack_cnt;
      repeat (4) @(negedge clk);
      #1;
      check("drop_single_ack", 32'(ack_cnt - a0), 32'd0);

      // ptr must now be 3: requester 3 beats 0, then 0 served on re-arbitration.
      lat = 2;
      set_op(0, 3'd4, 32'h0101_0101, 32'h1010_1010);
      set_op(3, 3'd7, 32'h7777_0000, 32'h0000_8888);
      push(4'b1000, model_res(3), 1'b0);
      push(4'b0001, model_res(0), 1'b0);
      req = 4'b1001;
      wait_ack(40, n);
      pop_check("ptr3_first");
      wait_ack(40, n);
      req = 4'b0000;
      pop_check("ptr3_second");
      gap();

`ifdef FDSP_ARB_TIMEOUT_EN
      // Watchdog: DSP never answers.
      lat = -1;
      s0  = rr_cnt;
      set_op(1, 3'd3, 32'h1111_2222, 32'h3333_4444);
      push(4'b0010, 32'h7FC0_0000, 1'b1);
      req = 4'b0010;
      wait_ack(100, n);
      req = 4'b0000;
      pop_check("timeout");
      @(negedge clk);
      #1;
      check("timeout_reset_req", 32'(rr_cnt - s0), 32'd1);
      gap();
      lat = 2;
      push(4'b0100, model_res(2), 1'b0);
      req = 4'b0100;
      wait_ack(40, n);
      req = 4'b0000;
      pop_check("after_timeout");
      gap();
`else
      check("reset_req_tied", 32'(rr_cnt), 32'd0);
`endif

      repeat (5) @(negedge clk);
      #1;
      check("total_acks", 32'(ack_cnt), 32'(n_push));
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
